// File: rtl/bht_gshare_multi_pkg.sv
// Shared types and helpers for the gshare/bimodal branch history table.
package bht_v3_pkg;

  typedef enum logic { BHT_BIMODAL, BHT_GSHARE } bht_mode_e;
  typedef enum logic { INIT, RUN } bht_fsm_e;

  // Widest counter the helper function can describe; the table itself
  // builds its entry struct from the real CTR_BITS.
  localparam int unsigned BHT_CTR_BITS_MAX = 8;

  // Weakly-not-taken reset value: 2^(ctr_bits-1) - 1.
  function automatic logic [BHT_CTR_BITS_MAX-1:0] weak_nt(input int unsigned ctr_bits);
    return BHT_CTR_BITS_MAX'((1 << (ctr_bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/bht_gshare_multi_sat_ctr.sv
// Combinational saturating up/down counter step.
module bht_sat_ctr #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  // Step toward taken/not-taken, holding at either rail.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != '1) ctr_o = ctr_i + 1'b1;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/bht_gshare_multi.sv
// Multi-lane branch history table with bimodal/gshare indexing, a
// registered read port, a global history register and a row-walking
// init/flush sequencer.
module bht_gshare_multi
  import bht_v3_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned GHR_LEN         = 8,
  parameter bht_mode_e   MODE            = BHT_GSHARE,
  parameter int unsigned VLEN            = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic                       lookup_valid_i,
  input  logic [VLEN-1:0]            vpc_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  output logic                       init_done_o
);

  localparam int unsigned IPF       = INSTR_PER_FETCH;
  localparam int unsigned NR_ROWS   = NR_ENTRIES / IPF;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned LANE_BITS = $clog2(IPF);
  localparam int unsigned LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(weak_nt(CTR_BITS));

  typedef struct packed {
    logic                valid;
    logic [CTR_BITS-1:0] ctr;
  } bht_entry_t;

  bht_entry_t tbl_q [NR_ROWS][IPF];
  bht_entry_t tbl_d [NR_ROWS][IPF];

  bht_fsm_e               state_q, state_d;
  logic [ROW_BITS-1:0]    row_cnt_q, row_cnt_d;
  logic [GHR_LEN-1:0]     ghr_q, ghr_d;
  logic [IPF-1:0]         pred_valid_q, pred_valid_d;
  logic [IPF-1:0]         pred_taken_q, pred_taken_d;

  logic [ROW_BITS-1:0]    look_row, upd_row;
  logic [LANE_W-1:0]      upd_lane;
  logic [IPF-1:0][CTR_BITS-1:0] upd_ctr;

  // Row selection; both ports hash with the GHR held at cycle start.
  function automatic logic [ROW_BITS-1:0] row_of(input logic [VLEN-1:0] pc,
                                                  input logic [GHR_LEN-1:0] ghr);
    logic [ROW_BITS-1:0] r;
    r = pc[1+LANE_BITS +: ROW_BITS];
    if (MODE == BHT_GSHARE) r = r ^ ROW_BITS'(ghr);
    return r;
  endfunction

  assign look_row = row_of(vpc_i, ghr_q);
  assign upd_row  = row_of(upd_pc_i, ghr_q);

  if (LANE_BITS > 0) begin : g_lane
    assign upd_lane = upd_pc_i[1 +: LANE_W];
  end else begin : g_one_lane
    assign upd_lane = '0;
  end

  // Upper pc bits are deliberately ignored (aliasing is allowed).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i, upd_pc_i};

  // One saturating counter step per lane of the addressed row.
  for (genvar i = 0; i < IPF; i++) begin : g_ctr
    bht_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
      .ctr_i   (tbl_q[upd_row][i].ctr),
      .taken_i (upd_taken_i),
      .ctr_o   (upd_ctr[i])
    );
  end

  // Sequencer, read port and read-modify-write update.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    ghr_d        = ghr_q;
    tbl_d        = tbl_q;
    pred_valid_d = '0;
    pred_taken_d = '0;
    if (flush_bp_i) begin
      state_d   = INIT;
      row_cnt_d = '0;
      ghr_d     = '0;
    end else if (state_q == INIT) begin
      for (int i = 0; i < IPF; i++) tbl_d[row_cnt_q][i] = '{valid: 1'b0, ctr: WEAK};
      row_cnt_d = row_cnt_q + 1'b1;
      if (row_cnt_q == ROW_BITS'(NR_ROWS - 1)) state_d = RUN;
    end else begin
      if (lookup_valid_i) begin
        for (int i = 0; i < IPF; i++) begin
          pred_valid_d[i] = tbl_q[look_row][i].valid;
          pred_taken_d[i] = tbl_q[look_row][i].ctr[CTR_BITS-1];
        end
      end
      if (upd_valid_i && !debug_mode_i) begin
        tbl_d[upd_row][upd_lane] = '{valid: 1'b1, ctr: upd_ctr[upd_lane]};
        ghr_d = GHR_LEN'({ghr_q, upd_taken_i});
      end
    end
  end

  // Control state and registered prediction outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= INIT;
      row_cnt_q    <= '0;
      ghr_q        <= '0;
      pred_valid_q <= '0;
      pred_taken_q <= '0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Table storage; cleared by the init walk rather than by reset.
  always_ff @(posedge clk_i) begin
    tbl_q <= tbl_d;
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign init_done_o  = (state_q == RUN);

endmodule

// File: tb/tb_bht_gshare_multi.sv
// Bench: one bimodal and one gshare instance share stimulus; a reference
// model pushes expected outputs into a scoreboard each cycle.
module tb_bht_gshare_multi;
  import bht_v3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, dbg, lv, uv, ut;
  logic [63:0] vpc, upc;
  logic [1:0]  pv_bi, pt_bi, pv_gs, pt_gs;
  logic        done_bi, done_gs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bht_gshare_multi #(.NR_ENTRIES(16), .INSTR_PER_FETCH(2), .CTR_BITS(2), .GHR_LEN(3),
                     .MODE(BHT_BIMODAL), .VLEN(64)) dut_bi (
    .clk_i(clk), .rst_ni(rst_n), .flush_bp_i(flush), .debug_mode_i(dbg),
    .lookup_valid_i(lv), .vpc_i(vpc), .pred_valid_o(pv_bi), .pred_taken_o(pt_bi),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_taken_i(ut), .init_done_o(done_bi));

  bht_gshare_multi #(.NR_ENTRIES(16), .INSTR_PER_FETCH(2), .CTR_BITS(2), .GHR_LEN(3),
                     .MODE(BHT_GSHARE), .VLEN(64)) dut_gs (
    .clk_i(clk), .rst_ni(rst_n), .flush_bp_i(flush), .debug_mode_i(dbg),
    .lookup_valid_i(lv), .vpc_i(vpc), .pred_valid_o(pv_gs), .pred_taken_o(pt_gs),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_taken_i(ut), .init_done_o(done_gs));

  typedef struct packed {
    logic [1:0] pvb, ptb, pvg, ptg;
    logic       dnb, dng;
  } exp_t;
  exp_t sb[$];

  // Reference model: index 0 = bimodal, 1 = gshare
  logic       m_v [2][8][2];
  logic [1:0] m_c [2][8][2];
  logic [2:0] m_ghr [2];
  bit         m_run;
  int         m_row;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int rowf(input int m, input logic [63:0] pc);
    int r;
    r = int'((pc >> 2) & 64'h7);
    if (m == 1) r = r ^ int'(m_ghr[1]);
    return r;
  endfunction

  // Advance the model one edge, push expectation, clock, then compare.
  task automatic tick();
    exp_t e;
    int r, l;
    logic [1:0] pv [2];
    logic [1:0] pt [2];
    pv = '{2'b00, 2'b00};
    pt = '{2'b00, 2'b00};
    if (!rst_n || flush) begin
      m_run = 0; m_row = 0; m_ghr = '{3'd0, 3'd0};
    end else if (!m_run) begin
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < 2; k++) begin
          m_v[m][m_row][k] = 1'b0;
          m_c[m][m_row][k] = 2'b01;
        end
      if (m_row == 7) m_run = 1;
      m_row = (m_row + 1) % 8;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (lv) begin
          r = rowf(m, vpc);
          for (int k = 0; k < 2; k++) begin
            pv[m][k] = m_v[m][r][k];
            pt[m][k] = m_c[m][r][k][1];
          end
        end
        if (uv && !dbg) begin
          r = rowf(m, upc);
          l = int'(upc[1]);
          m_v[m][r][l] = 1'b1;
          if (ut && m_c[m][r][l] != 2'b11) m_c[m][r][l] = m_c[m][r][l] + 2'b01;
          else if (!ut && m_c[m][r][l] != 2'b00) m_c[m][r][l] = m_c[m][r][l] - 2'b01;
          m_ghr[m] = {m_ghr[m][1:0], ut};
        end
      end
    end
    e.pvb = pv[0]; e.ptb = pt[0]; e.pvg = pv[1]; e.ptg = pt[1];
    e.dnb = m_run; e.dng = m_run;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pv_bi", pv_bi, e.pvb);
      chk("pt_bi", pt_bi, e.ptb);
      chk("pv_gs", pv_gs, e.pvg);
      chk("pt_gs", pt_gs, e.ptg);
      chk("done_bi", done_bi, e.dnb);
      chk("done_gs", done_gs, e.dng);
    end
  endtask

  task automatic idle();
    flush = 0; dbg = 0; lv = 0; uv = 0; ut = 0; vpc = '0; upc = '0;
  endtask

  // Count cycles until init_done rises, bounded.
  task automatic walk(output int n);
    n = 0;
    while (!done_bi && n < 40) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 8; r++)
        for (int k = 0; k < 2; k++) begin
          m_v[m][r][k] = 1'b0; m_c[m][r][k] = 2'b01;
        end
    m_ghr = '{3'd0, 3'd0}; m_run = 0; m_row = 0;
    idle();
    rst_n = 0;
    tick(); tick();
    chk("rst_done", done_bi, 1'b0);
    chk("rst_pv", pv_gs, 2'b00);
    rst_n = 1;

    // Init walk length, with lookups requested during INIT
    lv = 1; vpc = 64'h1000;
    walk(n);
    chk("init_len", n, 8);
    idle();

    // Saturate up with same-cycle lookup (old value shown each time)
    lv = 1; vpc = 64'h1000; uv = 1; upc = 64'h1000; ut = 1;
    repeat (3) tick();
    idle(); lv = 1; vpc = 64'h1000; tick();
    chk("sat_hi_v", pv_bi[0], 1'b1);
    chk("sat_hi_t", pt_bi[0], 1'b1);
    lv = 1; uv = 1; upc = 64'h1000; ut = 0;
    tick();
    idle(); lv = 1; vpc = 64'h1000; tick();
    chk("sat_hi_1nt", pt_bi[0], 1'b1);
    lv = 1; uv = 1; upc = 64'h1000; ut = 0;
    repeat (3) tick();
    idle(); lv = 1; vpc = 64'h1000; tick();
    chk("floor_t", pt_bi[0], 1'b0);
    chk("floor_v", pv_bi[0], 1'b1);
    chk("lane1_v", pv_bi[1], 1'b0);

    // Gshare: history T,T,N -> 110, next update lands at row 0^6
    idle(); flush = 1; tick(); flush = 0;
    walk(n);
    chk("flush_len", n, 8);
    uv = 1; upc = 64'h2000;
    ut = 1; tick(); tick();
    ut = 0; tick();
    upc = 64'h1000; ut = 1; lv = 1; vpc = 64'h1000; tick();
    chk("gs_pre_v", pv_gs[0], 1'b0);
    idle(); lv = 1; vpc = 64'h100C; tick();
    chk("gs_row6_v", pv_gs[0], 1'b1);
    chk("gs_row6_t", pt_gs[0], 1'b1);
    chk("bi_row3_v", pv_bi[0], 1'b0);

    // Read-before-write on one row, new value the next cycle
    idle(); lv = 1; vpc = 64'h1010; uv = 1; upc = 64'h1010; ut = 1; tick();
    chk("rbw_old", pv_bi[0], 1'b0);
    idle(); lv = 1; vpc = 64'h1010; tick();
    chk("rbw_new_v", pv_bi[0], 1'b1);
    chk("rbw_new_t", pt_bi[0], 1'b1);

    // Debug mode leaves table and history alone
    idle(); dbg = 1; uv = 1; upc = 64'h1018; ut = 1;
    repeat (3) tick();
    idle(); lv = 1; vpc = 64'h1018; tick();
    chk("dbg_v", pv_bi[0], 1'b0);
    idle(); uv = 1; upc = 64'h1004; ut = 0; tick();

    // Flush mid-RUN, then again mid-INIT; all entries invalid afterwards
    idle(); flush = 1; tick(); flush = 0;
    repeat (3) tick();
    flush = 1; tick(); flush = 0;
    walk(n);
    chk("reflush_len", n, 8);
    for (int r = 0; r < 8; r++) begin
      lv = 1; vpc = 64'(r << 2); tick();
      chk("clr_bi", pv_bi, 2'b00);
      chk("clr_gs", pv_gs, 2'b00);
    end

    // Random traffic in RUN
    for (int i = 0; i < 300; i++) begin
      lv  = 1'($urandom);
      vpc = 64'($urandom_range(0, 63));
      uv  = 1'($urandom);
      upc = 64'($urandom_range(0, 63));
      ut  = 1'($urandom);
      dbg = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
